// File: rtl/mem_pkg.sv
// Shared types and helpers for the mem_responder memory slave.
package mem_pkg;

  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  // Even parity: the stored check bit makes the XOR of the whole word zero.
  function automatic logic even_parity(input logic [MEM_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read output; maps onto block RAM.
module mem_array #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  // NOTE: the storage array is never reset; a reset loop would prevent block-RAM inference.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // The read register holds its value until the next read, and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// RD/WR/MFC four-phase memory slave with programmable wait states.
// Optional even-parity storage and PErr port: define MEM_RESPONDER_PARITY_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataWr,
  output logic [DATA_W-1:0] DataRd,
  output logic              MFC,
  output logic              ProtoErr
`ifdef MEM_RESPONDER_PARITY_EN
  ,
  output logic              PErr
`endif
);

`ifdef MEM_RESPONDER_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  state_t                state, state_nxt;
  op_t                   op;
  logic [3:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic                  rd_q, wr_q;
  logic                  mfc_nxt, proto_nxt;
  logic                  capture, access;
  logic                  strobe, opp, opp_q;
  logic [MW-1:0]         wfull, rfull;
  logic                  addr_unused;

  // Upper address bits alias away.
  assign addr_unused = ^Addr[ADDR_W-1:DEPTH_LOG2];

  assign strobe = (op == OP_RD) ? RD   : WR;
  assign opp    = (op == OP_RD) ? WR   : RD;
  assign opp_q  = (op == OP_RD) ? wr_q : rd_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mfc_nxt   = MFC;
    proto_nxt = 1'b0;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (RD && WR) begin
          proto_nxt = !(rd_q && wr_q);
        end else if (RD ^ WR) begin
          capture   = 1'b1;
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        proto_nxt = opp && !opp_q;
        cnt_nxt   = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACK;
      end
      ACK: begin
        proto_nxt = opp && !opp_q;
        // MFC still low means this is the entry edge: perform the access.
        if (!MFC) begin
          access  = 1'b1;
          mfc_nxt = 1'b1;
        end else if (!strobe) begin
          mfc_nxt   = 1'b0;
          state_nxt = REL;
        end
      end
      REL: begin
        mfc_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      MFC      <= 1'b0;
      ProtoErr <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      op       <= OP_RD;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      MFC      <= mfc_nxt;
      ProtoErr <= proto_nxt;
      rd_q     <= RD;
      wr_q     <= WR;
      if (capture) begin
        op     <= RD ? OP_RD : OP_WR;
        addr_q <= Addr[DEPTH_LOG2-1:0];
        data_q <= DataWr;
      end
    end
  end

`ifdef MEM_RESPONDER_PARITY_EN
  logic perr_win;

  assign wfull = {even_parity(data_q), data_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_win <= 1'b0;
    else        perr_win <= access && (op == OP_RD);
  end

  // Valid only in the cycle MFC rises, when the fresh read word sits in rfull.
  assign PErr = perr_win && (^rfull);
`else
  assign wfull = data_q;
`endif

  mem_array #(
    .WIDTH      (MW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (access),
    .we    (access && (op == OP_WR)),
    .addr  (addr_q),
    .wdata (wfull),
    .rdata (rfull)
  );

  assign DataRd = rfull[DATA_W-1:0];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: transaction-level timing model plus
// randomized RD/WR handshakes. Define MEM_RESPONDER_PARITY_EN to cover PErr.
module tb_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DL    = 12;
  localparam int WS    = 2;
  localparam int WORDS = 2**DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          RD, WR;
  logic [AW-1:0] Addr;
  logic [DW-1:0] DataWr;
  logic [DW-1:0] DataRd;
  logic          MFC, ProtoErr;
`ifdef MEM_RESPONDER_PARITY_EN
  logic          PErr;
`endif

  mem_responder #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH_LOG2  (DL),
    .WAIT_STATES (WS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RD       (RD),
    .WR       (WR),
    .Addr     (Addr),
    .DataWr   (DataWr),
    .DataRd   (DataRd),
    .MFC      (MFC),
    .ProtoErr (ProtoErr)
`ifdef MEM_RESPONDER_PARITY_EN
    ,
    .PErr     (PErr)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: word store plus expected output levels.
  logic [DW-1:0] mm  [WORDS];
  bit            kn  [WORDS];
  bit            bad [WORDS];
  int            wq[$];
  logic [DW-1:0] m_data;
  bit            m_data_ok;
  bit            m_mfc, m_proto, m_perr;
  bit            run_cmp = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      check("mfc", {31'd0, MFC}, {31'd0, m_mfc});
      check("proto_err", {31'd0, ProtoErr}, {31'd0, m_proto});
      if (m_data_ok) check("data_rd", {16'd0, DataRd}, {16'd0, m_data});
`ifdef MEM_RESPONDER_PARITY_EN
      check("perr", {31'd0, PErr}, {31'd0, m_perr});
`endif
    end
  end

  // One rising edge; single-cycle pulses in the model expire here.
  task automatic step();
    @(posedge clk);
    #1;
    m_proto = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic access(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold, input bit abort, input bit glitch,
                        output int lat, output logic perr_at_rise);
    int w;
    w            = int'(a[DL-1:0]);
    lat          = 0;
    perr_at_rise = 1'b0;
    RD = !is_wr; WR = is_wr; Addr = a; DataWr = d;
    step();
    Addr   = AW'($urandom);
    DataWr = DW'($urandom);
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == WS + 1) begin
        m_mfc = 1'b1;
        if (is_wr) begin
          mm[w] = d; kn[w] = 1'b1; bad[w] = 1'b0;
        end else begin
          m_data = mm[w]; m_data_ok = kn[w]; m_perr = bad[w];
        end
      end
      if (abort && n == 1) begin RD = 1'b0; WR = 1'b0; end
      if (glitch && n == 1) begin if (is_wr) RD = 1'b1; else WR = 1'b1; end
      if (glitch && n == 2) begin
        m_proto = 1'b1;
        if (is_wr) RD = 1'b0; else WR = 1'b0;
      end
      if (MFC === 1'b1 && lat == 0) begin
        lat = n;
`ifdef MEM_RESPONDER_PARITY_EN
        perr_at_rise = PErr;
`endif
      end
      if (n >= WS + 1 && lat != 0) break;
    end
    check("latency", 32'(lat), 32'(WS + 1));
    for (int h = 0; h < hold; h++) step();
    RD = 1'b0; WR = 1'b0;
    step();
    m_mfc = 1'b0;
    step();
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat; logic pe;
    access(1'b1, a, d, 0, 1'b0, 1'b0, lat, pe);
    wq.push_back(int'(a[DL-1:0]));
  endtask

  task automatic rd_word(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    int lat; logic pe;
    access(1'b0, a, '0, 0, 1'b0, 1'b0, lat, pe);
    check(name, {16'd0, DataRd}, {16'd0, exp});
  endtask

  initial begin
    int          lat;
    logic        pe;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset = 1'b0; RD = 1'b0; WR = 1'b0; Addr = '0; DataWr = '0;
    m_data = '0; m_data_ok = 1'b1; m_mfc = 1'b0; m_proto = 1'b0; m_perr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_mfc", {31'd0, MFC}, 32'd0);
    check("reset_datard", {16'd0, DataRd}, 32'd0);
    check("reset_proto", {31'd0, ProtoErr}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    run_cmp = 1'b1;

    // Basic write then read with literal latency and data.
    access(1'b1, 16'h0005, 16'hBEEF, 0, 1'b0, 1'b0, lat, pe);
    wq.push_back(5);
    check("wr_latency_lit", 32'(lat), 32'd3);
    access(1'b0, 16'h0005, '0, 0, 1'b0, 1'b0, lat, pe);
    check("rd_latency_lit", 32'(lat), 32'd3);
    check("rd_beef", {16'd0, DataRd}, 32'h0000_BEEF);

    // Aliasing: top of address space and word 0 coexist.
    wr_word(16'hFFFF, 16'h1234);
    rd_word(16'h0FFF, 16'h1234, "alias_0fff");
    wr_word(16'h0000, 16'h5A5A);
    rd_word(16'hFFFF, 16'h1234, "alias_ffff");

    // Both strobes together in IDLE: one-cycle error, no access.
    RD = 1'b1; WR = 1'b1; Addr = 16'h0005; DataWr = 16'hDEAD;
    step();
    m_proto = 1'b1;
    check("both_proto", {31'd0, ProtoErr}, 32'd1);
    check("both_no_mfc", {31'd0, MFC}, 32'd0);
    RD = 1'b0; WR = 1'b0;
    step();
    check("both_proto_end", {31'd0, ProtoErr}, 32'd0);
    repeat (2) step();
    rd_word(16'h0005, 16'hBEEF, "both_ram_kept");

    // Long hold: MFC stays up, no second access.
    access(1'b0, 16'h0000, '0, 10, 1'b0, 1'b0, lat, pe);
    check("hold_data", {16'd0, DataRd}, 32'h0000_5A5A);

    // Opposite strobe during WAIT, then an aborted write.
    access(1'b0, 16'h0FFF, '0, 1, 1'b0, 1'b1, lat, pe);
    check("glitch_data", {16'd0, DataRd}, 32'h0000_1234);
    access(1'b1, 16'h0042, 16'h7777, 0, 1'b1, 1'b0, lat, pe);
    wq.push_back(16'h042);
    rd_word(16'h0042, 16'h7777, "abort_wr_done");

    // Reset in the WAIT phase of a write discards it.
    wr_word(16'h0010, 16'h1111);
    rd_word(16'h0005, 16'hBEEF, "pre_reset_rd");
    RD = 1'b0; WR = 1'b1; Addr = 16'h0010; DataWr = 16'hAAAA;
    step();
    step();
    #2;
    reset = 1'b0; WR = 1'b0;
    m_mfc = 1'b0; m_data = '0; m_data_ok = 1'b1;
    #1;
    check("midrst_mfc", {31'd0, MFC}, 32'd0);
    check("midrst_datard", {16'd0, DataRd}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    rd_word(16'h0010, 16'h1111, "midrst_old_kept");

`ifdef MEM_RESPONDER_PARITY_EN
    wr_word(16'h0020, 16'h0F0F);
    dut.u_array.mem[32][DW] = ~dut.u_array.mem[32][DW];
    bad[32] = 1'b1;
    access(1'b0, 16'h0020, '0, 0, 1'b0, 1'b0, lat, pe);
    check("perr_bad", {31'd0, pe}, 32'd1);
    check("perr_bad_data", {16'd0, DataRd}, 32'h0000_0F0F);
    access(1'b0, 16'h0005, '0, 0, 1'b0, 1'b0, lat, pe);
    check("perr_clean", {31'd0, pe}, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      bit is_wr, ab, gl;
      int hold;
      is_wr = ($urandom_range(0, 1) == 1);
      ab    = ($urandom_range(0, 4) == 0);
      gl    = !ab && ($urandom_range(0, 7) == 0);
      hold  = ab ? 0 : int'($urandom_range(0, 3));
      a     = AW'($urandom);
      d     = DW'($urandom);
      if (is_wr) begin
        wq.push_back(int'(a[DL-1:0]));
      end else begin
        logic [DL-1:0] idx;
        idx = DL'(wq[$urandom_range(0, wq.size() - 1)]);
        a[DL-1:0] = idx;
      end
      access(is_wr, a, d, hold, ab, gl, lat, pe);
      repeat ($urandom_range(0, 2)) step();
    end

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
